// File: rtl/checkout_scan_controller.sv
// checkout_scan_controller
//
// Controller for the checkout datapath. A rising edge on the scan request
// latches one item (3-bit UPC plus security mark). The item is then evaluated
// with the discount/stolen rule:
//   D = P | (U & C)
//   S = ~M & ~P & ~(U & C)
// It also keeps saturating totals of items, discounted items and stolen items.
// A stolen item latches the theft alarm. While the alarm is latched, scans are
// refused until an acknowledge edge arrives.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high; clears all state
//   upc[2:0]   item code {U,P,C}, asynchronous, sampled in CAPTURE
//   mark       security mark M, asynchronous, sampled in CAPTURE
//   scan       level scan request; each rising edge requests one scan
//   ack        level alarm acknowledge; each rising edge is one acknowledge
//   item_upc   UPC of the last accepted item
//   disc       last accepted item is discounted
//   stolen     last accepted item is stolen
//   alarm      latched theft alarm
//   busy       scan in progress or alarm latched
//   item_cnt   total accepted items (saturating)
//   disc_cnt   total discounted items (saturating)
//   stolen_cnt total stolen items (saturating)
module checkout_scan_controller #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       upc,
  input  logic             mark,
  input  logic             scan,
  input  logic             ack,
  output logic [2:0]       item_upc,
  output logic             disc,
  output logic             stolen,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic [CNT_W-1:0] stolen_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_EVAL    = 2'd2,
    S_ALARM   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scan_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_scan_prev;
  logic                   r_ack_prev;
  logic                   r_ack_p;
  logic [2:0]             r_item_upc;
  logic                   r_item_mark;

  logic w_scan_p;
  logic w_ack_rise;
  logic w_uc;
  logic w_d;
  logic w_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The MSB of each synchronizer shift register is the oldest and safe sample.
  assign w_scan_p   = r_scan_sync[SYNC_STAGES-1] & ~r_scan_prev;
  assign w_ack_rise = r_ack_sync[SYNC_STAGES-1] & ~r_ack_prev;

  // Detector on the latched item. D and S are mutually exclusive by construction.
  assign w_uc = r_item_upc[2] & r_item_upc[0];
  assign w_d  = r_item_upc[1] | w_uc;
  assign w_s  = ~r_item_mark & ~r_item_upc[1] & ~w_uc;

  // Input conditioning. The ack pulse has one extra register stage, so the
  // alarm clears SYNC_STAGES+2 edges after ack rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_sync <= '0;
      r_ack_sync  <= '0;
      r_scan_prev <= 1'b0;
      r_ack_prev  <= 1'b0;
      r_ack_p     <= 1'b0;
    end else begin
      r_scan_sync <= (r_scan_sync << 1) | SYNC_STAGES'(scan);
      r_ack_sync  <= (r_ack_sync << 1) | SYNC_STAGES'(ack);
      r_scan_prev <= r_scan_sync[SYNC_STAGES-1];
      r_ack_prev  <= r_ack_sync[SYNC_STAGES-1];
      r_ack_p     <= w_ack_rise;
    end
  end

  // Control FSM with registered outputs and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_item_upc  <= 3'd0;
      r_item_mark <= 1'b0;
      item_upc    <= 3'd0;
      disc        <= 1'b0;
      stolen      <= 1'b0;
      alarm       <= 1'b0;
      busy        <= 1'b0;
      item_cnt    <= '0;
      disc_cnt    <= '0;
      stolen_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_scan_p) begin
            r_state <= S_CAPTURE;
            busy    <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_item_upc  <= upc;
          r_item_mark <= mark;
          r_state     <= S_EVAL;
        end
        S_EVAL: begin
          item_upc <= r_item_upc;
          disc     <= w_d;
          stolen   <= w_s;
          item_cnt <= sat_inc(item_cnt);
          if (w_d) disc_cnt <= sat_inc(disc_cnt);
          if (w_s) begin
            stolen_cnt <= sat_inc(stolen_cnt);
            alarm      <= 1'b1;
            r_state    <= S_ALARM;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ALARM: begin
          // Scan pulses here are dropped; only an ack leaves this state.
          if (r_ack_p) begin
            alarm   <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checkout_scan_controller.sv
module tb_checkout_scan_controller;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [2:0]       upc;
  logic             mark;
  logic             scan;
  logic             ack;
  logic [2:0]       item_upc;
  logic             disc;
  logic             stolen;
  logic             alarm;
  logic             busy;
  logic [CNT_W-1:0] item_cnt;
  logic [CNT_W-1:0] disc_cnt;
  logic [CNT_W-1:0] stolen_cnt;

  checkout_scan_controller #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .upc(upc), .mark(mark), .scan(scan), .ack(ack),
    .item_upc(item_upc), .disc(disc), .stolen(stolen), .alarm(alarm),
    .busy(busy), .item_cnt(item_cnt), .disc_cnt(disc_cnt),
    .stolen_cnt(stolen_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int m_upc, m_disc, m_stolen, m_alarm, m_item, m_dcnt, m_scnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    m_upc = 0; m_disc = 0; m_stolen = 0; m_alarm = 0;
    m_item = 0; m_dcnt = 0; m_scnt = 0;
  endtask

  task automatic check_all();
    chk("item_upc", 32'(item_upc), m_upc);
    chk("disc", 32'(disc), m_disc);
    chk("stolen", 32'(stolen), m_stolen);
    chk("alarm", 32'(alarm), m_alarm);
    chk("busy", 32'(busy), m_alarm);
    chk("item_cnt", 32'(item_cnt), m_item);
    chk("disc_cnt", 32'(disc_cnt), m_dcnt);
    chk("stolen_cnt", 32'(stolen_cnt), m_scnt);
  endtask

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  // Apply an accepted (or, when alarmed, refused) item to the model.
  task automatic model_scan(input int u, input int m);
    int bu, bp, bc, d, s;
    if (m_alarm != 0) return;
    bu = (u >> 2) & 1; bp = (u >> 1) & 1; bc = u & 1;
    d = (bp == 1 || (bu == 1 && bc == 1)) ? 1 : 0;
    s = (m == 0 && d == 0) ? 1 : 0;
    m_upc = u; m_disc = d; m_stolen = s;
    m_item = sat(m_item);
    if (d != 0) m_dcnt = sat(m_dcnt);
    if (s != 0) begin m_scnt = sat(m_scnt); m_alarm = 1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; scan = 1'b0; ack = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Raise scan just after an edge; that next edge is edge 0.
  task automatic do_scan(input int u, input int m);
    int old_item;
    @(posedge clk); #1;
    upc = 3'(u); mark = m[0];
    scan = 1'b1;
    old_item = m_item;
    repeat (3) @(posedge clk);
    #1 chk("busy_capture", 32'(busy), 1);
    @(posedge clk);
    #1 chk("item_cnt_early", 32'(item_cnt), old_item);
    @(posedge clk);
    model_scan(u, m);
    #1 check_all();
    scan = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    @(posedge clk); #1;
    ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("alarm_ack_early", 32'(alarm), m_alarm);
    @(posedge clk);
    m_alarm = 0;
    #1 check_all();
    ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int old_item;
    reset = 1'b1; upc = 3'd0; mark = 1'b0; scan = 1'b0; ack = 1'b0;
    model_clear();
    do_reset();

    // Discounted item, then a stolen item with a refused scan and an ack.
    do_scan(3'b010, 1);
    do_scan(3'b000, 0);
    do_scan(3'b101, 1);
    do_ack();

    // Level held high: one item; a second edge landing in EVAL is dropped.
    @(posedge clk); #1;
    upc = 3'b110; mark = 1'b1; scan = 1'b1;
    @(posedge clk); #1 scan = 1'b0;
    @(posedge clk); #1 scan = 1'b1;
    model_scan(3'b110, 1);
    repeat (20) @(posedge clk);
    #1 check_all();
    scan = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Scan and ack rising together while alarmed.
    do_scan(3'b001, 0);
    old_item = m_item;
    @(posedge clk); #1;
    scan = 1'b1; ack = 1'b1;
    repeat (4) @(posedge clk);
    m_alarm = 0;
    #1 check_all();
    chk("item_cnt_scan_ack", 32'(item_cnt), old_item);
    scan = 1'b0; ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    do_scan(3'b011, 1);

    // Asynchronous reset while alarmed with two stolen items counted.
    do_reset();
    do_scan(3'b100, 0);
    do_ack();
    do_scan(3'b000, 0);
    chk("stolen_cnt_two", 32'(stolen_cnt), 2);
    @(posedge clk); #3;
    reset = 1'b1;
    model_clear();
    #1 check_all();
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_scan(3'b111, 1);

    // Saturation.
    do_reset();
    for (int i = 0; i < 17; i++) do_scan(3'b101, 1);
    chk("item_cnt_sat", 32'(item_cnt), CNT_MAX);
    chk("disc_cnt_sat", 32'(disc_cnt), CNT_MAX);
    chk("stolen_cnt_sat", 32'(stolen_cnt), 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (m_alarm != 0 && $urandom_range(0, 2) != 0) do_ack();
      else do_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
